// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the round-robin write-arbitrated FIFO controller.
package fifo_pkg;

  // Pointers carry one extra bit so full and empty are distinguishable.
  function automatic int ptr_width(input int addrsize);
    return addrsize + 1;
  endfunction

  function automatic int idx_width(input int nreq);
    return (nreq <= 1) ? 1 : $clog2(nreq);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from the producer after the last winner and
// grants the first requester, remembering the winner for the next search.
module rr_arbiter
  import fifo_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = idx_width(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt
);

  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] win_idx;
  logic [IW:0]   cand;
  logic          found;

  // NOTE: every signal written here gets a default first, otherwise a path
  // that skips the assignment would infer a latch.
  always_comb begin
    cand    = '0;
    found   = 1'b0;
    win_idx = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = {1'b0, last_q} + (IW+1)'(i);
      if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
      if (!found && req[cand[IW-1:0]]) begin
        found   = 1'b1;
        win_idx = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    gnt    = '0;
    last_d = last_q;
    if (en && found) begin
      gnt[win_idx] = 1'b1;
      last_d       = win_idx;
    end
  end

  // Reset to the highest index so producer 0 is searched first.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    if (rst) last_q <= IW'(NREQ - 1);
    else     last_q <= last_d;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Single-clock FIFO controller sharing one fifomem write port among NREQ
// producers by round-robin arbitration, with a pop/empty consumer side.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int DATASIZE     = 8,
  parameter int ADDRSIZE     = 4,
  parameter int NREQ         = 4,
  parameter int AFULL_MARGIN = 2
) (
  input  logic                     wclk,
  input  logic                     wrst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DATASIZE-1:0] req_data,
  output logic [NREQ-1:0]          gnt,
  input  logic                     pop,
  output logic [DATASIZE-1:0]      rdata,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic [ADDRSIZE:0]        count,
  output logic                     underflow,
  output logic [ADDRSIZE-1:0]      mem_waddr,
  output logic [ADDRSIZE-1:0]      mem_raddr,
  output logic [DATASIZE-1:0]      mem_wdata,
  output logic                     mem_wclken,
  output logic                     mem_wfull,
  input  logic [DATASIZE-1:0]      mem_rdata
);

  localparam int PW    = ptr_width(ADDRSIZE);
  localparam int DEPTH = 1 << ADDRSIZE;

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          underflow_q, underflow_d;
  logic          push;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk (wclk),
    .rst (wrst),
    .en  (!full && !wrst),
    .req (req),
    .gnt (gnt)
  );

  assign push  = |gnt;
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[PW-1] != rptr_q[PW-1]) &&
                 (wptr_q[ADDRSIZE-1:0] == rptr_q[ADDRSIZE-1:0]);
  assign count = wptr_q - rptr_q;
  assign almost_full = (PW'(DEPTH) - count) <= PW'(AFULL_MARGIN);
  assign underflow   = underflow_q;

  assign mem_waddr  = wptr_q[ADDRSIZE-1:0];
  assign mem_raddr  = rptr_q[ADDRSIZE-1:0];
  assign mem_wclken = push;
  assign mem_wfull  = full;
  assign rdata      = mem_rdata;

  // Grant is one-hot, so OR-ing the gated slices selects the winner's data.
  always_comb begin
    mem_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) mem_wdata = mem_wdata | req_data[i*DATASIZE +: DATASIZE];
    end
  end

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    underflow_d = underflow_q;
    if (push) wptr_d = wptr_q + PW'(1);
    if (pop) begin
      if (empty) underflow_d = 1'b1;
      else       rptr_d      = rptr_q + PW'(1);
    end
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      underflow_q <= underflow_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized directed bench for fifo_wr_arbiter against a queue-based model,
// with a behavioural fifomem attached to the RAM-side ports.
module tb_fifo_wr_arbiter;

  localparam int DS     = 8;
  localparam int AS     = 4;
  localparam int NREQ   = 4;
  localparam int MARGIN = 2;
  localparam int DEPTH  = 1 << AS;

  logic               wclk = 1'b0;
  logic               wrst;
  logic [NREQ-1:0]    req;
  logic [NREQ*DS-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic               pop;
  logic [DS-1:0]      rdata;
  logic               empty, full, almost_full, underflow;
  logic [AS:0]        count;
  logic [AS-1:0]      mem_waddr, mem_raddr;
  logic [DS-1:0]      mem_wdata, mem_rdata;
  logic               mem_wclken, mem_wfull;

  fifo_wr_arbiter #(
    .DATASIZE(DS), .ADDRSIZE(AS), .NREQ(NREQ), .AFULL_MARGIN(MARGIN)
  ) dut (
    .wclk(wclk), .wrst(wrst), .req(req), .req_data(req_data), .gnt(gnt),
    .pop(pop), .rdata(rdata), .empty(empty), .full(full),
    .almost_full(almost_full), .count(count), .underflow(underflow),
    .mem_waddr(mem_waddr), .mem_raddr(mem_raddr), .mem_wdata(mem_wdata),
    .mem_wclken(mem_wclken), .mem_wfull(mem_wfull), .mem_rdata(mem_rdata)
  );

  always #5 wclk = ~wclk;

  // Behavioural fifomem: clocked write, asynchronous read.
  logic [DS-1:0] ram [DEPTH];
  always @(posedge wclk) if (mem_wclken && !mem_wfull) ram[mem_waddr] <= mem_wdata;
  assign mem_rdata = ram[mem_raddr];

  int n_cmp = 0;
  int n_bad = 0;

  logic [DS-1:0] m_q [$];
  logic [DS-1:0] pdata [NREQ];
  int  m_last;
  bit  m_uf;
  int  m_wcnt, m_rcnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] r);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_last = NREQ - 1;
    m_uf   = 1'b0;
    m_wcnt = 0;
    m_rcnt = 0;
  endtask

  // One clock: drive at the falling edge, check combinational outputs,
  // advance the model at the rising edge, check status at the next fall.
  task automatic cycle(input logic [NREQ-1:0] r, input logic p, input logic rst);
    int g;
    int pre;
    logic [NREQ-1:0] eg;
    logic [DS-1:0]   ed;
    req  = r;
    pop  = p;
    wrst = rst;
    for (int i = 0; i < NREQ; i++) req_data[i*DS +: DS] = pdata[i];
    #1;
    pre = m_q.size();
    g   = (rst || pre == DEPTH) ? -1 : pick(r);
    eg  = '0;
    ed  = '0;
    if (g >= 0) begin
      eg[g] = 1'b1;
      ed    = pdata[g];
    end
    check("gnt", 32'(gnt), 32'(eg));
    check("mem_wclken", 32'(mem_wclken), 32'(g >= 0));
    check("mem_wdata", 32'(mem_wdata), 32'(ed));
    check("mem_waddr", 32'(mem_waddr), 32'(m_wcnt % DEPTH));
    check("mem_raddr", 32'(mem_raddr), 32'(m_rcnt % DEPTH));
    check("mem_wfull", 32'(mem_wfull), 32'(pre == DEPTH));
    @(posedge wclk);
    if (rst) begin
      model_reset();
    end else begin
      if (p) begin
        if (pre == 0) m_uf = 1'b1;
        else begin
          void'(m_q.pop_front());
          m_rcnt++;
        end
      end
      if (g >= 0) begin
        m_q.push_back(pdata[g]);
        m_last = g;
        m_wcnt++;
      end
    end
    if (g >= 0) pdata[g] = DS'($urandom);
    @(negedge wclk);
    check("count", 32'(count), 32'(m_q.size()));
    check("empty", 32'(empty), 32'(m_q.size() == 0));
    check("full", 32'(full), 32'(m_q.size() == DEPTH));
    check("almost_full", 32'(almost_full), 32'((DEPTH - m_q.size()) <= MARGIN));
    check("underflow", 32'(underflow), 32'(m_uf));
    if (m_q.size() != 0) check("rdata", 32'(rdata), 32'(m_q[0]));
  endtask

  initial begin
    logic [NREQ-1:0] r;
    for (int i = 0; i < NREQ; i++) pdata[i] = DS'($urandom);
    req      = '0;
    pop      = 1'b0;
    req_data = '0;
    wrst     = 1'b1;
    repeat (2) @(negedge wclk);
    model_reset();

    // Reset then idle, then a single push from producer 0 and its pop.
    cycle('0, 1'b0, 1'b1);
    cycle('0, 1'b0, 1'b0);
    cycle(4'b0001, 1'b0, 1'b0);
    cycle('0, 1'b1, 1'b0);

    // Round-robin with all producers requesting, starting fresh from reset.
    cycle('0, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) cycle(4'b1111, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) cycle('0, 1'b1, 1'b0);

    // Fill to full, then keep requesting while full.
    for (int k = 0; k < 40 && m_q.size() < DEPTH; k++) begin
      r = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      cycle(r, 1'b0, 1'b0);
    end
    for (int k = 0; k < 3; k++) cycle(4'b1111, 1'b0, 1'b0);

    // Full with simultaneous pop and request: blocked now, resumes next.
    cycle(4'b1010, 1'b1, 1'b0);
    cycle(4'b1010, 1'b0, 1'b0);

    // Drain to 8, then sustained push/pop pairs so both pointers wrap.
    for (int k = 0; k < 20 && m_q.size() > 8; k++) cycle('0, 1'b1, 1'b0);
    for (int k = 0; k < 40; k++) begin
      r = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      cycle(r, 1'b1, 1'b0);
    end

    // Drain, pop while empty, then push and pop together while empty.
    for (int k = 0; k < 20 && m_q.size() > 0; k++) cycle('0, 1'b1, 1'b0);
    cycle('0, 1'b1, 1'b0);
    cycle('0, 1'b0, 1'b0);
    cycle(4'b0100, 1'b1, 1'b0);

    // Reset mid-stream at count 5 with requests and a pop present.
    for (int k = 0; k < 10 && m_q.size() < 5; k++) cycle(4'b0011, 1'b0, 1'b0);
    cycle(4'b1111, 1'b1, 1'b1);
    cycle('0, 1'b0, 1'b0);

    // Free-running random traffic.
    for (int k = 0; k < 200; k++) begin
      r = NREQ'($urandom);
      cycle(r, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 99) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Single-clock FIFO controller that shares the write port of the `fifomem` dual-port RAM among NREQ producers using round-robin arbitration. It owns the write and read pointers, drives the RAM's `waddr`/`raddr`/`wclken`/`wfull`/`wdata`, and exposes a pop/empty interface to one consumer. It sits directly beside one `fifomem` instance and is the only agent that drives that instance.

## Interface
Parameters:
- DATASIZE, 8, word width; must match the `fifomem` instance.
- ADDRSIZE, 4, RAM address bits; depth = 2^ADDRSIZE.
- NREQ, 4, number of producers (2..8).
- AFULL_MARGIN, 2, `almost_full` asserts when free slots ≤ AFULL_MARGIN.

Ports:
- wclk  in  1  clock; all logic on the rising edge.
- wrst  in  1  reset, synchronous, active-high.
- req  in  NREQ  producer i requests a write.
- req_data  in  NREQ*DATASIZE  producer i data at bits [i*DATASIZE +: DATASIZE].
- gnt  out  NREQ  one-hot accept; the write occurs on the edge ending the cycle in which gnt[i]=1.
- pop  in  1  consumer removes the head word.
- rdata  out  DATASIZE  head word; equals mem_rdata; valid only while !empty.
- empty, full, almost_full  out  1  status.
- count  out  ADDRSIZE+1  occupancy, 0..2^ADDRSIZE.
- underflow  out  1  sticky; pop seen while empty.
- mem_waddr, mem_raddr  out  ADDRSIZE  RAM addresses.
- mem_wdata  out  DATASIZE  granted producer's data.
- mem_wclken  out  1  asserted when a write is granted.
- mem_wfull  out  1  equals full.
- mem_rdata  in  DATASIZE  RAM asynchronous read data.

## Operation
- Pointers: wptr and rptr are ADDRSIZE+1-bit binary. Addresses are the low ADDRSIZE bits. Pointers wrap naturally at 2^(ADDRSIZE+1).
- Flags (derived combinationally from the registered pointers):
  - empty = (wptr == rptr).
  - full = MSBs differ and low bits are equal.
  - count = wptr − rptr, modulo 2^(ADDRSIZE+1).
  - almost_full = (2^ADDRSIZE − count) ≤ AFULL_MARGIN.
- Arbitration: round-robin pointer `last` holds the index of the last granted producer.
  - Search order is last+1, last+2, … mod NREQ. The first requester found gets gnt.
  - gnt is combinational from req, `last`, full and wrst.
  - gnt = 0 when full or wrst=1.
  - On a grant: wptr++, `last` ← granted index.
  - Without a grant, `last` holds.
- Write path: mem_wclken = |gnt. mem_wdata = slice of the granted producer, or 0 when no grant.
- Read path: pop && !empty → rptr++ at the edge.
  - pop && empty → no pointer change; underflow ← 1, held until wrst.
- Simultaneous push and pop:
  - Not full and not empty: both pointers advance; count is unchanged.
  - Full: push is blocked this cycle regardless of pop. The pop still occurs, so a grant is possible the next cycle.
  - Empty: push is accepted and pop sets underflow. The word is not consumed.
- A producer holds req and req_data until it sees gnt. Dropping req without a grant is legal; nothing is written.

## Timing
- Reset (wrst high at an edge): wptr = rptr = 0; `last` = NREQ−1, so req[0] has first priority; underflow = 0.
  - Resulting outputs: empty=1, full=0, almost_full=0 (AFULL_MARGIN < depth), count=0, gnt=0, mem_wclken=0, mem_waddr=mem_raddr=0.
- Reset mid-operation discards all contents in one cycle. Any grant in that cycle is suppressed.
- Write to visible: data written at edge N; empty deasserts and rdata is valid after edge N. Latency is 1 cycle.
- Pop to next word: rdata shows the next word after the popping edge, through the RAM's asynchronous read.
- Flags, count and the status outputs change only after a clock edge.
- gnt/mem_* respond combinationally within the cycle to req and full.

## Structure
- Package `fifo_pkg`: ptr width function (ADDRSIZE+1) and a `clog2`-based index width for NREQ.
- Sub-module `rr_arbiter` (NREQ, enable input, req in, gnt out, last-grant register): the natural split. The top level holds the pointers, flags and RAM muxing.
- The top level plus `rr_arbiter` target roughly 150–250 lines.

## Test plan
- Reset then idle: after wrst, empty=1, count=0, gnt=0. One cycle with req=4'b0001 → gnt=0001, count=1 next cycle, rdata = req_data[0].
- Round-robin: req=4'b1111 held for 8 cycles → grants 0,1,2,3,0,1,2,3. Pop-out order matches the data tags.
- Fill to full (depth 16, AFULL_MARGIN=2): almost_full rises at count=14, full at 16. Further req → gnt=0, no write, wptr stable.
- Full with pop: pop at count=16 plus req → no grant that cycle, count=15. Next cycle the grant resumes and count=16.
- Wrap-around: 40 push/pop pairs at count≈8 → pointers wrap past 31→0, data order intact, flags correct throughout.
- Underflow and reset: pop while empty → underflow=1, count stays 0. Assert wrst mid-stream at count=5 → count=0, underflow=0, empty=1 on the next cycle.
